// File: rtl/fpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fpu_ctrl_pkg
// Shared definitions for the FPU pipeline controller: operation codes,
// divider FSM state encoding, the per-stage tracking tag and a small decode
// helper used by the issue logic.
// -----------------------------------------------------------------------------
package fpu_ctrl_pkg;

    // Operation codes presented on ReqOp0 / ReqOp1 and echoed on IssueOp.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Shared iterative divider sequencing states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // Per-stage bookkeeping carried alongside the arithmetic datapath.
    typedef struct packed {
        logic       valid;
        logic [1:0] op;
        logic       req;
    } stage_tag_t;

    // Divides go to the shared iterative unit; everything else to the pipeline.
    function automatic logic is_div_op(input logic [1:0] op);
        return (op == OP_DIV);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. The grant is purely combinational from the
// (already qualified) request vector; the priority pointer flips toward the
// requester that was not served whenever a grant is given.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (pointer favours requester 0)
//   req    in   [1:0] qualified requests
//   gnt    out  [1:0] one-hot grant (or zero)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import fpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 1'b1 means requester 1 wins a tie
    logic prio_r;

    // One-hot grant selection, pointer only matters under contention
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !prio_r)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
    end

    // Priority pointer: favour whoever was not granted most recently
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_r <= 1'b0;
        end else if (gnt[0]) begin
            prio_r <= 1'b1;
        end else if (gnt[1]) begin
            prio_r <= 1'b0;
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/fpu_pipe_controller.sv
// -----------------------------------------------------------------------------
// fpu_pipe_controller
// Control plane for an FPU with a PipeDepth-stage add/sub/mul pipeline and a
// shared iterative divider. Arbitrates two requesters, tracks valid/tag per
// pipeline stage, sequences the divider and arbitrates the result mux.
//
// Parameters:
//   PipeDepth   pipeline stages (2..8)
//   DivCycles   divider occupancy per divide (2..63)
//
// Ports:
//   Clk          in   clock
//   Reset        in   synchronous active-high reset
//   ReqValid     in   [1:0] per-requester request
//   ReqOp0/1     in   [1:0] op code per requester
//   ReqAck       out  [1:0] one-hot combinational grant
//   IssueOp      out  [1:0] granted op code
//   IssueValid   out  operand capture strobe
//   StageEn      out  [PipeDepth-1:0] pipeline register load enables
//   DivStart     out  divider start pulse
//   ResultValid  out  result present at the output mux
//   ResultSel    out  mux select (0 pipeline, 1 divider)
//   ResultTag    out  requester owning the presented result
//   ResultReady  in   consumer accepts the presented result
// -----------------------------------------------------------------------------
module fpu_pipe_controller
    import fpu_ctrl_pkg::*;
#(
    parameter int PipeDepth = 4,
    parameter int DivCycles = 12
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [1:0]           ReqValid,
    input  logic [1:0]           ReqOp0,
    input  logic [1:0]           ReqOp1,
    output logic [1:0]           ReqAck,
    output logic [1:0]           IssueOp,
    output logic                 IssueValid,
    output logic [PipeDepth-1:0] StageEn,
    output logic                 DivStart,
    output logic                 ResultValid,
    output logic                 ResultSel,
    output logic                 ResultTag,
    input  logic                 ResultReady
);

    localparam int              CntW    = (DivCycles > 1) ? $clog2(DivCycles) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(DivCycles - 1);
    localparam int              Last    = PipeDepth - 1;

    stage_tag_t      stage_r [PipeDepth];
    stage_tag_t      stage_in_s;

    div_state_e      div_state_r;
    div_state_e      div_state_s;
    logic [CntW-1:0] div_cnt_r;
    logic [CntW-1:0] div_cnt_s;
    logic            div_tag_r;
    logic            div_tag_s;

    logic            last_valid_s;
    logic            stall_s;
    logic            div_idle_s;
    logic            div_done_s;
    logic            div_accept_s;
    logic [1:0]      elig_s;
    logic [1:0]      gnt_s;
    logic [1:0]      grant_op_s;
    logic            grant_idx_s;
    logic            issue_pipe_s;
    logic            div_start_s;

    // Pipeline / divider status used by issue and output logic
    always_comb begin
        last_valid_s = stage_r[Last].valid;
        // The pipeline always wins the output mux, so it stalls only on its own result
        stall_s      = last_valid_s & ~ResultReady;
        div_idle_s   = (div_state_r == DIV_IDLE);
        div_done_s   = (div_state_r == DIV_DONE);
        // Divider result is only taken when the pipeline is not presenting
        div_accept_s = div_done_s & ~last_valid_s & ResultReady;
    end

    // Qualify requests so a blocked op never steals the grant from the other side
    always_comb begin
        elig_s = 2'b00;
        if (Reset) begin
            elig_s = 2'b00;
        end else begin
            elig_s[0] = ReqValid[0] & (is_div_op(ReqOp0) ? div_idle_s : ~stall_s);
            elig_s[1] = ReqValid[1] & (is_div_op(ReqOp1) ? div_idle_s : ~stall_s);
        end
    end

    rr_arbiter2 u_arb (
        .clk   (Clk),
        .reset (Reset),
        .req   (elig_s),
        .gnt   (gnt_s)
    );

    // Decode the winning request into a pipeline issue or a divider start
    always_comb begin
        grant_idx_s  = 1'b0;
        grant_op_s   = OP_ADD;
        issue_pipe_s = 1'b0;
        div_start_s  = 1'b0;
        stage_in_s   = '0;
        if (gnt_s[1]) begin
            grant_idx_s = 1'b1;
            grant_op_s  = ReqOp1;
        end else if (gnt_s[0]) begin
            grant_idx_s = 1'b0;
            grant_op_s  = ReqOp0;
        end else begin
            grant_idx_s = 1'b0;
            grant_op_s  = OP_ADD;
        end
        if (gnt_s != 2'b00) begin
            issue_pipe_s = ~is_div_op(grant_op_s);
            div_start_s  = is_div_op(grant_op_s);
        end else begin
            issue_pipe_s = 1'b0;
            div_start_s  = 1'b0;
        end
        if (issue_pipe_s) begin
            stage_in_s.valid = 1'b1;
            stage_in_s.op    = grant_op_s;
            stage_in_s.req   = grant_idx_s;
        end else begin
            stage_in_s = '0;
        end
    end

    // Valid/tag shift register; frozen as a whole while the last stage is stalled
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < PipeDepth; k++) begin
                stage_r[k] <= '0;
            end
        end else if (!stall_s) begin
            stage_r[0] <= stage_in_s;
            for (int k = 1; k < PipeDepth; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    // Divider FSM next state; the counter moves only while BUSY
    always_comb begin
        div_state_s = div_state_r;
        div_cnt_s   = div_cnt_r;
        div_tag_s   = div_tag_r;
        case (div_state_r)
            DIV_IDLE: begin
                if (div_start_s) begin
                    div_state_s = DIV_BUSY;
                    div_cnt_s   = CntLoad;
                    div_tag_s   = grant_idx_s;
                end else begin
                    div_state_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                // Reaching zero on this edge completes the occupancy window
                if (div_cnt_r == CntW'(1)) begin
                    div_state_s = DIV_DONE;
                    div_cnt_s   = div_cnt_r - CntW'(1);
                end else if (div_cnt_r == '0) begin
                    div_state_s = DIV_DONE;
                end else begin
                    div_cnt_s   = div_cnt_r - CntW'(1);
                end
            end
            DIV_DONE: begin
                if (div_accept_s) begin
                    div_state_s = DIV_IDLE;
                end else begin
                    div_state_s = DIV_DONE;
                end
            end
            default: begin
                div_state_s = DIV_IDLE;
                div_cnt_s   = '0;
                div_tag_s   = 1'b0;
            end
        endcase
    end

    // Divider FSM state, counter and owner registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_state_r <= DIV_IDLE;
            div_cnt_r   <= '0;
            div_tag_r   <= 1'b0;
        end else begin
            div_state_r <= div_state_s;
            div_cnt_r   <= div_cnt_s;
            div_tag_r   <= div_tag_s;
        end
    end

    // Output drive; forced quiet while Reset is asserted so nothing stale leaks out
    always_comb begin
        ReqAck      = 2'b00;
        IssueOp     = 2'b00;
        IssueValid  = 1'b0;
        StageEn     = '0;
        DivStart    = 1'b0;
        ResultValid = 1'b0;
        ResultSel   = 1'b0;
        ResultTag   = 1'b0;
        if (Reset) begin
            ReqAck = 2'b00;
        end else begin
            ReqAck      = gnt_s;
            IssueValid  = (gnt_s != 2'b00);
            IssueOp     = (gnt_s != 2'b00) ? grant_op_s : 2'b00;
            StageEn     = stall_s ? '0 : {PipeDepth{1'b1}};
            DivStart    = div_start_s;
            ResultValid = last_valid_s | div_done_s;
            ResultSel   = ~last_valid_s & div_done_s;
            if (last_valid_s) begin
                ResultTag = stage_r[Last].req;
            end else if (div_done_s) begin
                ResultTag = div_tag_r;
            end else begin
                ResultTag = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_pipe_controller.sv
// -----------------------------------------------------------------------------
// tb_fpu_pipe_controller
// Directed scenarios followed by randomized traffic. A transaction-level model
// (in-flight op ages, absolute divider completion time, round-robin preference)
// predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_fpu_pipe_controller;
    import fpu_ctrl_pkg::*;

    localparam int PD = 4;
    localparam int DC = 12;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [1:0]    ReqValid;
    logic [1:0]    ReqOp0;
    logic [1:0]    ReqOp1;
    logic [1:0]    ReqAck;
    logic [1:0]    IssueOp;
    logic          IssueValid;
    logic [PD-1:0] StageEn;
    logic          DivStart;
    logic          ResultValid;
    logic          ResultSel;
    logic          ResultTag;
    logic          ResultReady;

    fpu_pipe_controller #(.PipeDepth(PD), .DivCycles(DC)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqOp0      (ReqOp0),
        .ReqOp1      (ReqOp1),
        .ReqAck      (ReqAck),
        .IssueOp     (IssueOp),
        .IssueValid  (IssueValid),
        .StageEn     (StageEn),
        .DivStart    (DivStart),
        .ResultValid (ResultValid),
        .ResultSel   (ResultSel),
        .ResultTag   (ResultTag),
        .ResultReady (ResultReady)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    int age_q[$];      // cycles each pipeline op has spent in the pipe (1 = just issued)
    int req_q[$];      // owner of each pipeline op, oldest first
    int pref;          // requester that wins a tie
    bit div_active;
    int div_done_at;   // absolute cycle at which the divide result appears
    int div_req;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        age_q.delete();
        req_q.delete();
        pref        = 0;
        div_active  = 1'b0;
        div_done_at = 0;
        div_req     = 0;
    endtask

    // Drive one cycle, compare all outputs against the model, then advance the model
    task automatic run_cycle(input logic rst, input logic [1:0] v, input logic [1:0] o0,
                             input logic [1:0] o1, input logic rdy);
        bit pv, stall, dd, el0, el1;
        int g, gop;
        logic [1:0]    e_ack;
        logic [PD-1:0] e_en;
        logic [1:0]    e_iop;
        bit e_iv, e_ds, e_rv, e_sel, e_tag;

        @(negedge Clk);
        Reset       = rst;
        ReqValid    = v;
        ReqOp0      = o0;
        ReqOp1      = o1;
        ResultReady = rdy;
        #1;

        if (rst) begin
            e_ack = 2'b00; e_iv = 1'b0; e_iop = 2'b00; e_ds = 1'b0; e_en = '0;
            e_rv = 1'b0; e_sel = 1'b0; e_tag = 1'b0; g = -1; gop = 0;
            pv = 1'b0; stall = 1'b0; dd = 1'b0;
        end else begin
            pv    = (age_q.size() > 0) && (age_q[0] == PD);
            stall = pv && !rdy;
            dd    = div_active && (cyc >= div_done_at);
            el0   = v[0] && ((o0 == OP_DIV) ? !div_active : !stall);
            el1   = v[1] && ((o1 == OP_DIV) ? !div_active : !stall);
            if (el0 && el1) g = pref;
            else if (el0)   g = 0;
            else if (el1)   g = 1;
            else            g = -1;
            gop   = (g == 1) ? int'(o1) : int'(o0);
            e_ack = (g == 0) ? 2'b01 : ((g == 1) ? 2'b10 : 2'b00);
            e_iv  = (g >= 0);
            e_iop = (g >= 0) ? 2'(gop) : 2'b00;
            e_ds  = (g >= 0) && (gop == 3);
            e_en  = stall ? '0 : {PD{1'b1}};
            e_rv  = pv || dd;
            e_sel = !pv && dd;
            e_tag = pv ? req_q[0][0] : (dd ? div_req[0] : 1'b0);
        end

        check_eq("ReqAck",      32'(ReqAck),      32'(e_ack));
        check_eq("IssueValid",  32'(IssueValid),  32'(e_iv));
        check_eq("IssueOp",     32'(IssueOp),     32'(e_iop));
        check_eq("DivStart",    32'(DivStart),    32'(e_ds));
        check_eq("StageEn",     32'(StageEn),     32'(e_en));
        check_eq("ResultValid", 32'(ResultValid), 32'(e_rv));
        check_eq("ResultSel",   32'(ResultSel),   32'(e_sel));
        check_eq("ResultTag",   32'(ResultTag),   32'(e_tag));

        if (rst) begin
            model_reset();
        end else begin
            if (dd && !pv && rdy) div_active = 1'b0;
            if (!stall) begin
                if (pv) begin
                    age_q.delete(0);
                    req_q.delete(0);
                end
                foreach (age_q[i]) age_q[i] = age_q[i] + 1;
            end
            if (g >= 0) begin
                if (gop == 3) begin
                    div_active  = 1'b1;
                    div_done_at = cyc + DC;
                    div_req     = g;
                end else begin
                    age_q.push_back(1);
                    req_q.push_back(g);
                end
                pref = 1 - g;
            end
        end
        cyc++;
        @(posedge Clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 2'b00, OP_ADD, OP_ADD, rdy);
    endtask

    initial begin
        Reset = 1'b1; ReqValid = 2'b00; ReqOp0 = OP_ADD; ReqOp1 = OP_ADD; ResultReady = 1'b1;
        model_reset();

        // Reset state
        run_cycle(1'b1, 2'b11, OP_ADD, OP_MUL, 1'b1);
        run_cycle(1'b1, 2'b00, OP_ADD, OP_ADD, 1'b1);

        // Single add from requester 0: result PD cycles after the grant
        run_cycle(1'b0, 2'b01, OP_ADD, OP_ADD, 1'b1);
        idle(PD + 2, 1'b1);

        // Both requesters streaming: alternating grants, one result per cycle
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 2'b11, OP_ADD, OP_SUB, 1'b1);
        idle(PD + 1, 1'b1);

        // Full pipe held off for three cycles, then released
        for (int i = 0; i < PD; i++) run_cycle(1'b0, 2'b11, OP_MUL, OP_ADD, 1'b1);
        for (int i = 0; i < 3; i++)  run_cycle(1'b0, 2'b11, OP_MUL, OP_ADD, 1'b0);
        for (int i = 0; i < 4; i++)  run_cycle(1'b0, 2'b11, OP_MUL, OP_ADD, 1'b1);
        idle(PD + 1, 1'b1);

        // Requester 0 keeps asking for divides while requester 1 streams muls
        for (int i = 0; i < 2 * DC + 6; i++) run_cycle(1'b0, 2'b11, OP_DIV, OP_MUL, 1'b1);
        idle(DC + PD, 1'b1);

        // Divider completion collides with a pipeline result
        run_cycle(1'b0, 2'b01, OP_DIV, OP_ADD, 1'b1);
        idle(DC - PD - 1, 1'b1);
        run_cycle(1'b0, 2'b10, OP_ADD, OP_SUB, 1'b1);
        idle(PD + 3, 1'b1);

        // Reset with ops in flight and the divider busy
        run_cycle(1'b0, 2'b01, OP_DIV, OP_ADD, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 2'b10, OP_ADD, OP_MUL, 1'b1);
        run_cycle(1'b1, 2'b11, OP_ADD, OP_ADD, 1'b1);
        idle(DC + PD, 1'b1);

        // Randomized traffic with occasional back-pressure and resets
        for (int i = 0; i < 3000; i++) begin
            run_cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                      2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end
        idle(DC + PD + 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
